// File: rtl/mod5_pkg.sv
// Shared types and helpers for the serial MSB framer and its mod-5 residue reference.
package mod5_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned MOD   = 5;
   localparam int unsigned RES_W = 3;
   localparam int unsigned TMP_W = RES_W + 1;

   // One MSB-first residue step: (2r + b) mod 5. With r < 5 the sum is < 10, so one subtract suffices.
   function automatic logic [RES_W-1:0] mod5_step(input logic [RES_W-1:0] r, input logic b);
      logic [TMP_W-1:0] t;
      t = {r, b};
      if (t >= TMP_W'(MOD)) begin
         t = t - TMP_W'(MOD);
      end
      return t[RES_W-1:0];
   endfunction

endpackage

// File: rtl/mod5_ref_acc.sv
// Mod-5 residue accumulator, MSB-first. Present only when MOD5_REF_EN is defined.
`ifdef MOD5_REF_EN
module mod5_ref_acc
   import mod5_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             bit_i,
   output logic [RES_W-1:0] residue_o
);

   logic [RES_W-1:0] res_q;

   // Residue register: clear wins over enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q <= '0;
      end else if (clr_i) begin
         res_q <= '0;
      end else if (en_i) begin
         res_q <= mod5_step(res_q, bit_i);
      end
   end

   assign residue_o = res_q;

endmodule
`endif

// File: rtl/serial_msb_framer.sv
// Parallel-to-serial MSB-first framer feeding a downstream mod-5 residue FSM.
// Each frame: clear pulse (CLR_CYCLES), len data bits, one DONE cycle.
// Optional MOD5_REF_EN adds an internal reference residue (ref_residue/ref_valid).
module serial_msb_framer
   import mod5_pkg::*;
#(
   parameter  int unsigned WIDTH      = 10,
   parameter  int unsigned CLR_CYCLES = 1,
   localparam int unsigned LW         = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LW-1:0]    in_len,
   output logic             ser_clr,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             frame_last,
   output logic             frame_done,
   output logic             busy
`ifdef MOD5_REF_EN
   ,
   output logic [RES_W-1:0] ref_residue,
   output logic             ref_valid
`endif
);

   localparam int unsigned CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

   state_e           state_q;
   logic [WIDTH-1:0] data_q;
   logic [LW-1:0]    len_q;
   logic [LW-1:0]    bit_cnt_q;
   logic [CW-1:0]    clr_cnt_q;
   logic             in_ready_q, ser_clr_q, ser_bit_q, ser_valid_q;
   logic             frame_last_q, frame_done_q, busy_q;
   logic [LW-1:0]    len_d;
   logic [LW-1:0]    shamt_d;

   // Clamp the offered length and left-align the frame so its MSB sits at data_q[WIDTH-1].
   always_comb begin
      len_d   = (in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
      shamt_d = LW'(WIDTH) - len_d;
   end

`ifdef MOD5_REF_EN
   logic [RES_W-1:0] acc_res;
   logic [RES_W-1:0] ref_residue_q;
   logic             ref_valid_q;

   mod5_ref_acc u_acc (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (ser_clr_q),
      .en_i      (ser_valid_q),
      .bit_i     (ser_bit_q),
      .residue_o (acc_res)
   );
`endif

   // Framer FSM with registered outputs; outputs are set for the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         data_q       <= '0;
         len_q        <= '0;
         bit_cnt_q    <= '0;
         clr_cnt_q    <= '0;
         in_ready_q   <= 1'b1;
         ser_clr_q    <= 1'b0;
         ser_bit_q    <= 1'b0;
         ser_valid_q  <= 1'b0;
         frame_last_q <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef MOD5_REF_EN
         ref_residue_q <= '0;
         ref_valid_q   <= 1'b0;
`endif
      end else begin
         frame_done_q <= 1'b0;
`ifdef MOD5_REF_EN
         ref_residue_q <= '0;
         ref_valid_q   <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_q    <= CLEAR;
                  data_q     <= in_data << shamt_d;
                  len_q      <= len_d;
                  clr_cnt_q  <= '0;
                  bit_cnt_q  <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  ser_clr_q  <= 1'b1;
                  ser_bit_q  <= 1'b0;
               end
            end
            CLEAR: begin
               if (clr_cnt_q == CW'(CLR_CYCLES - 1)) begin
                  ser_clr_q <= 1'b0;
                  if (len_q == '0) begin
                     state_q      <= DONE;
                     frame_done_q <= 1'b1;
`ifdef MOD5_REF_EN
                     ref_valid_q  <= 1'b1;
`endif
                  end else begin
                     state_q      <= SHIFT;
                     ser_valid_q  <= 1'b1;
                     ser_bit_q    <= data_q[WIDTH-1];
                     data_q       <= data_q << 1;
                     frame_last_q <= (len_q == LW'(1));
                     bit_cnt_q    <= LW'(1);
                  end
               end else begin
                  clr_cnt_q <= clr_cnt_q + CW'(1);
               end
            end
            SHIFT: begin
               if (bit_cnt_q == len_q) begin
                  state_q      <= DONE;
                  ser_valid_q  <= 1'b0;
                  ser_bit_q    <= 1'b0;
                  frame_last_q <= 1'b0;
                  frame_done_q <= 1'b1;
`ifdef MOD5_REF_EN
                  // Accumulator absorbs the last bit on this same edge; fold it in here.
                  ref_residue_q <= mod5_step(acc_res, ser_bit_q);
                  ref_valid_q   <= 1'b1;
`endif
               end else begin
                  ser_bit_q    <= data_q[WIDTH-1];
                  data_q       <= data_q << 1;
                  frame_last_q <= (bit_cnt_q == len_q - LW'(1));
                  bit_cnt_q    <= bit_cnt_q + LW'(1);
               end
            end
            DONE: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign ser_clr    = ser_clr_q;
   assign ser_bit    = ser_bit_q;
   assign ser_valid  = ser_valid_q;
   assign frame_last = frame_last_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;
`ifdef MOD5_REF_EN
   assign ref_residue = ref_residue_q;
   assign ref_valid   = ref_valid_q;
`endif

endmodule

// File: tb/tb_serial_msb_framer.sv
// Directed self-checking bench for serial_msb_framer with a downstream mod-5 FSM model.
// Build with MOD5_REF_EN to also check ref_residue/ref_valid; override CLR_CYCLES for the clear-length build.
module tb_serial_msb_framer #(
   parameter int unsigned CLR_CYCLES = 1
);

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] in_data;
   logic [3:0] in_len;
   logic       ser_clr, ser_bit, ser_valid, frame_last, frame_done, busy;
`ifdef MOD5_REF_EN
   logic [2:0] ref_residue;
   logic       ref_valid;
   logic [2:0] gold_res;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_msb_framer #(.WIDTH(10), .CLR_CYCLES(CLR_CYCLES)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_len     (in_len),
      .ser_clr    (ser_clr),
      .ser_bit    (ser_bit),
      .ser_valid  (ser_valid),
      .frame_last (frame_last),
      .frame_done (frame_done),
      .busy       (busy)
`ifdef MOD5_REF_EN
      ,
      .ref_residue (ref_residue),
      .ref_valid   (ref_valid)
`endif
   );

`ifdef MOD5_REF_EN
   mod5_ref_acc u_gold (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (ser_clr),
      .en_i      (ser_valid),
      .bit_i     (ser_bit),
      .residue_o (gold_res)
   );
`endif

   // Downstream residue FSM: cleared by ser_clr, samples ser_bit on every edge.
   logic [2:0] ds_r;
   always @(posedge clk or posedge ser_clr or posedge reset) begin
      if (reset || ser_clr) ds_r <= 3'd0;
      else                  ds_r <= 3'({ds_r, ser_bit} % 4'd5);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Send one word and check the whole frame up to and including its DONE cycle.
   task automatic do_frame(input string tag, input logic [9:0] d, input logic [3:0] len,
                           input logic [9:0] exp_bits, input int exp_n, input int exp_res,
                           input bit noise);
      int guard, i, nclr, nbits, lastpos, first_idx, ready_bad, clr_pos_bad;
      logic [9:0] got_bits;
`ifdef MOD5_REF_EN
      int ref_bad = 0;
`endif
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({tag, ":ready_before"}, 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = d;
      in_len   = len;
      @(negedge clk);
      in_valid = noise;
      i = 0; nclr = 0; nbits = 0; lastpos = -1; first_idx = -1;
      ready_bad = 0; clr_pos_bad = 0; got_bits = '0;
      while (!frame_done && i < 40) begin
         if (in_ready) ready_bad++;
         if (ser_clr) begin
            nclr++;
            if (i >= int'(CLR_CYCLES)) clr_pos_bad++;
         end
         if (ser_valid) begin
            if (first_idx < 0) first_idx = i;
            got_bits = {got_bits[8:0], ser_bit};
            nbits++;
            if (frame_last) lastpos = nbits;
         end
`ifdef MOD5_REF_EN
         if (ref_valid) ref_bad++;
`endif
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 10'($urandom);
            in_len   = 4'($urandom);
         end
         @(negedge clk);
         i++;
      end
      in_valid = 1'b0;
      check({tag, ":done_seen"}, 32'(frame_done), 1);
      check({tag, ":done_cycle"}, i, int'(CLR_CYCLES) + exp_n);
      check({tag, ":clr_cycles"}, nclr, int'(CLR_CYCLES));
      check({tag, ":clr_position"}, clr_pos_bad, 0);
      if (exp_n > 0) check({tag, ":first_bit_idx"}, first_idx, int'(CLR_CYCLES));
      check({tag, ":nbits"}, nbits, exp_n);
      check({tag, ":bits"}, 32'(got_bits), 32'(exp_bits));
      check({tag, ":last_pos"}, lastpos, (exp_n == 0) ? -1 : exp_n);
      check({tag, ":ready_low"}, ready_bad, 0);
      check({tag, ":done_ready"}, 32'(in_ready), 0);
      check({tag, ":done_busy"}, 32'(busy), 1);
      check({tag, ":done_bit"}, 32'({ser_bit, ser_valid, frame_last, ser_clr}), 0);
      check({tag, ":residue"}, 32'(ds_r), exp_res);
`ifdef MOD5_REF_EN
      check({tag, ":ref_early"}, ref_bad, 0);
      check({tag, ":ref_valid"}, 32'(ref_valid), 1);
      check({tag, ":ref_residue"}, 32'(ref_residue), exp_res);
      check({tag, ":ref_vs_gold"}, 32'(ref_residue), 32'(gold_res));
`endif
   endtask

   initial begin
      int guard, nb;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_len   = '0;
      repeat (2) @(negedge clk);
      check("rst:in_ready", 32'(in_ready), 1);
      check("rst:outs", 32'({ser_clr, ser_bit, ser_valid, frame_last, frame_done, busy}), 0);
`ifdef MOD5_REF_EN
      check("rst:ref", 32'({ref_valid, ref_residue}), 0);
`endif
      reset = 1'b0;

      do_frame("f723", 10'd723, 4'd10, 10'b1011010011, 10, 3, 1'b0);
      do_frame("f54",  10'd54,  4'd6,  10'b0000110110, 6, 4, 1'b0);
      do_frame("f31",  10'd31,  4'd5,  10'b0000011111, 5, 1, 1'b0);
      do_frame("len0", 10'd723, 4'd0,  10'b0000000000, 0, 0, 1'b0);
      do_frame("clamp", 10'd512, 4'd15, 10'b1000000000, 10, 2, 1'b0);

      // Abort a frame with reset while its fourth bit is on the line.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 10'd723;
      in_len   = 4'd10;
      check("abort:ready_before", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      nb = 0;
      guard = 0;
      while (nb < 4 && guard < 30) begin
         @(negedge clk);
         if (ser_valid) nb++;
         guard++;
      end
      check("abort:reached_bit4", nb, 4);
      check("abort:bit4_value", 32'({ser_valid, ser_bit}), 3);
      #2 reset = 1'b1;
      #1;
      check("abort:in_ready", 32'(in_ready), 1);
      check("abort:outs", 32'({ser_clr, ser_bit, ser_valid, frame_last, frame_done, busy}), 0);
`ifdef MOD5_REF_EN
      check("abort:ref", 32'({ref_valid, ref_residue}), 0);
`endif
      @(negedge clk);
      reset = 1'b0;
      do_frame("post_abort", 10'd723, 4'd10, 10'b1011010011, 10, 3, 1'b0);

      // Offers while busy must be ignored.
      do_frame("noise723", 10'd723, 4'd10, 10'b1011010011, 10, 3, 1'b1);
      do_frame("noise54",  10'd54,  4'd6,  10'b0000110110, 6, 4, 1'b1);

      @(negedge clk);
      check("final:idle", 32'({in_ready, busy}), 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
